fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control FSM. Owns the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. Splits each word into op_code/op1/op2/op3/immed fields and presents them to the control FSM over a valid/ready handshake. Accepts a PC redirect from branch/jump resolution.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/instr_field_decode.sv | 20 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, ALU operators, fetch states.
package cpu_pkg;

    localparam int INSTR_W   = 16;
    localparam int OPCODE_W  = 4;
    localparam int REG_W     = 4;
    localparam int IMMED_W   = 8;

    localparam int OPCODE_LSB = 12;
    localparam int OP1_LSB    = 8;
    localparam int OP2_LSB    = 4;
    localparam int OP3_LSB    = 0;
    localparam int IMMED_LSB  = 0;

    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_MULT  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_SW    = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_LW    = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_RSVD7 = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_NAND  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_DIV   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_MOD   = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_ROTL  = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_BLE   = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_BGE   = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_J     = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_MULT = 3'd2,
        ALU_NAND = 3'd3,
        ALU_DIV  = 3'd4,
        ALU_MOD  = 3'd5,
        ALU_ROTL = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational split of an instruction word into its fields; zero latency, no flow control.
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]  ir,
    output logic [OPCODE_W-1:0] op_code,
    output logic [REG_W-1:0]    op1,
    output logic [REG_W-1:0]    op2,
    output logic [REG_W-1:0]    op3,
    output logic [IMMED_W-1:0]  immed
);

    assign op_code = ir[OPCODE_LSB +: OPCODE_W];
    assign op1     = ir[OP1_LSB    +: REG_W];
    assign op2     = ir[OP2_LSB    +: REG_W];
    assign op3     = ir[OP3_LSB    +: REG_W];
    // Immediate is left raw; sign extension belongs to the consumer.
    assign immed   = ir[IMMED_LSB  +: IMMED_W];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/ack, registered IR presented over valid/ready; redirect wins everywhere.
// One instruction per 2 cycles at best; while an instruction is held unaccepted no new fetch is issued.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    INSTR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    OPCODE_WIDTH   = 4,
    parameter int                    REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    input  logic                      imem_ack,
    input  logic [INSTR_WIDTH-1:0]    imem_rdata,
    input  logic                      redirect,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [OPCODE_WIDTH-1:0]   op_code,
    output logic [REG_ADDR_WIDTH-1:0] op1,
    output logic [REG_ADDR_WIDTH-1:0] op2,
    output logic [REG_ADDR_WIDTH-1:0] op3,
    output logic [7:0]                immed,
    output logic [ADDR_WIDTH-1:0]     instr_pc,
    output logic [ADDR_WIDTH-1:0]     pc
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   instr_valid_q, instr_valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            instr_pc_q    <= '0;
            ir_q          <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            ir_q          <= ir_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        ir_d          = ir_q;
        instr_valid_d = instr_valid_q;
        imem_req      = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                if (redirect) pc_d = redirect_pc;
                state_d = FS_FETCH;
            end
            FS_FETCH: begin
                imem_req = 1'b1;
                // A redirect discards any data returned in the same cycle.
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (imem_ack) begin
                    ir_d          = imem_rdata;
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + ADDR_WIDTH'(1);
                    instr_valid_d = 1'b1;
                    state_d       = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = FS_FETCH;
                end else if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = FS_FETCH;
                end
            end
            default: begin
                state_d       = FS_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    instr_field_decode u_decode (
        .ir      (ir_q),
        .op_code (op_code),
        .op1     (op1),
        .op2     (op2),
        .op3     (op3),
        .immed   (immed)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of the fetch handshake followed by a randomized run against a transaction-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  op_code, op1, op2, op3;
    logic [7:0]  immed;
    logic [15:0] instr_pc;
    logic [15:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_code     (op_code),
        .op1         (op1),
        .op2         (op2),
        .op3         (op3),
        .immed       (immed),
        .instr_pc    (instr_pc),
        .pc          (pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [15:0] word);
        chk({tag, ".op_code"}, 32'(op_code), 32'(word / 16'h1000));
        chk({tag, ".op1"},     32'(op1),     32'((word / 16'h0100) % 16));
        chk({tag, ".op2"},     32'(op2),     32'((word / 16'h0010) % 16));
        chk({tag, ".op3"},     32'(op3),     32'(word % 16));
        chk({tag, ".immed"},   32'(immed),   32'(word % 256));
    endtask

    // Transaction-level model: an instruction is either held for the consumer or being fetched,
    // with one dead cycle after reset release.
    logic        m_dead, m_held;
    logic [15:0] m_pc, m_word, m_ipc;

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.imem_req", 32'(imem_req), 0);
        chk("rst.instr_valid", 32'(instr_valid), 0);
        chk("rst.pc", 32'(pc), 0);
        chk("rst.instr_pc", 32'(instr_pc), 0);
        chk_fields("rst", 16'h0000);

        // 1: same-cycle ack of 0x0123 at address 0
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0123; instr_ready = 1'b1;
        chk("t1.idle_req", 32'(imem_req), 0);
        @(negedge clk);
        chk("t1.fetch_req", 32'(imem_req), 1);
        chk("t1.fetch_addr", 32'(imem_addr), 0);
        @(negedge clk);
        chk("t1.valid", 32'(instr_valid), 1);
        chk_fields("t1", 16'h0123);
        chk("t1.instr_pc", 32'(instr_pc), 0);
        chk("t1.pc", 32'(pc), 1);
        imem_ack = 1'b0;
        @(negedge clk);

        // 2: ack delayed 3 cycles
        instr_ready = 1'b0;
        imem_rdata = 16'hA5C3;
        for (int i = 0; i < 4; i++) begin
            chk("t2.req", 32'(imem_req), 1);
            chk("t2.addr", 32'(imem_addr), 1);
            chk("t2.valid", 32'(instr_valid), 0);
            if (i == 3) imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("t2.valid_out", 32'(instr_valid), 1);
        chk("t2.instr_pc", 32'(instr_pc), 1);
        chk("t2.pc", 32'(pc), 2);
        chk_fields("t2", 16'hA5C3);

        // 3: consumer stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("t3.valid", 32'(instr_valid), 1);
            chk("t3.req", 32'(imem_req), 0);
            chk("t3.instr_pc", 32'(instr_pc), 1);
            chk("t3.op_code", 32'(op_code), 32'h A);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk("t3.valid_drop", 32'(instr_valid), 0);
        chk("t3.req_next", 32'(imem_req), 1);
        chk("t3.addr_next", 32'(imem_addr), 2);

        // 4: redirect coincident with ack in FETCH
        imem_ack = 1'b1; imem_rdata = 16'hFFFF; redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0;
        chk("t4.valid", 32'(instr_valid), 0);
        chk("t4.req", 32'(imem_req), 1);
        chk("t4.addr", 32'(imem_addr), 32'h40);

        // 5: redirect in HOLD with ready squashes the held instruction
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t5.valid_first", 32'(instr_valid), 1);
        chk("t5.ipc_first", 32'(instr_pc), 32'h40);
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        chk("t5.squash", 32'(instr_valid), 0);
        chk("t5.addr", 32'(imem_addr), 32'h100);
        imem_ack = 1'b1; imem_rdata = 16'h5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t5.valid", 32'(instr_valid), 1);
        chk("t5.instr_pc", 32'(instr_pc), 32'h100);
        chk_fields("t5", 16'h5678);

        // 6: PC wrap, then reset mid-FETCH with redirect held
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        chk("t6.addr", 32'(imem_addr), 32'hFFFF);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t6.instr_pc", 32'(instr_pc), 32'hFFFF);
        chk("t6.pc_wrap", 32'(pc), 0);
        chk_fields("t6", 16'hBEEF);
        redirect = 1'b1; redirect_pc = 16'h0077;
        @(negedge clk);
        chk("t6.pre_rst_addr", 32'(imem_addr), 32'h77);
        #2 rst = 1'b0;
        #1;
        chk("t6.rst_req", 32'(imem_req), 0);
        chk("t6.rst_pc", 32'(pc), 0);
        chk("t6.rst_valid", 32'(instr_valid), 0);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("t6.rst_redirect_pc", 32'(pc), 0);
        chk("t6.rst_ack_req", 32'(imem_req), 0);

        // Randomized run
        redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        rst = 1'b1;
        m_dead = 1'b1; m_held = 1'b0; m_pc = '0; m_word = '0; m_ipc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd.req", 32'(imem_req), 32'(!m_dead && !m_held));
            chk("rnd.pc", 32'(pc), 32'(m_pc));
            chk("rnd.valid", 32'(instr_valid), 32'(m_held));
            if (imem_req) chk("rnd.addr", 32'(imem_addr), 32'(m_pc));
            chk("rnd.instr_pc", 32'(instr_pc), 32'(m_ipc));
            chk_fields("rnd", m_word);

            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 16'($urandom);
            imem_ack    = $urandom_range(0, 1) == 1;
            imem_rdata  = 16'($urandom);
            instr_ready = $urandom_range(0, 2) != 0;

            if (redirect) begin
                m_pc   = redirect_pc;
                m_held = 1'b0;
                m_dead = 1'b0;
            end else if (m_dead) begin
                m_dead = 1'b0;
            end else if (!m_held) begin
                if (imem_ack) begin
                    m_word = imem_rdata;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 16'd1;
                    m_held = 1'b1;
                end
            end else if (instr_ready) begin
                m_held = 1'b0;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
